// File: rtl/sigdelay_pkg.sv
// Shared types and constants for the microphone delay-line sequencing controller.
package sigdelay_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } ctrl_state_t;

    localparam int OFFSET_MIN  = 1;
    localparam int A_WIDTH_DEF = 9;

endpackage

// File: rtl/sigdelay_fill_counter.sv
// Saturating count of samples written since the last (re)prime of the delay buffer.
module sigdelay_fill_counter
    import sigdelay_pkg::*;
#(
    parameter int A_WIDTH = A_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               ld1_i,
    input  logic               inc_i,
    input  logic [A_WIDTH-1:0] max_i,
    output logic [A_WIDTH-1:0] count_o
);

    localparam logic [A_WIDTH-1:0] ONE = A_WIDTH'(1);

    logic [A_WIDTH-1:0] count_q;
    logic [A_WIDTH-1:0] count_d;

    // Load-to-1 wins over clear: it is the first write under a freshly loaded offset.
    always_comb begin
        count_d = count_q;
        if (ld1_i) begin
            count_d = ONE;
        end else if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q < max_i)) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/sigdelay_ctrl.sv
// Delay-line sequencer: turns sample ticks into en/wr/rd strobes, primes the RAM
// after start or an offset change, and flags when the read data is a genuine delayed sample.
module sigdelay_ctrl
    import sigdelay_pkg::*;
#(
    parameter int A_WIDTH = A_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               sample_tick,
    input  logic [A_WIDTH-1:0] offset_in,
    input  logic               offset_load,
    output logic               en,
    output logic               wr,
    output logic               rd,
    output logic [A_WIDTH-1:0] offset,
    output logic               out_valid,
    output logic [A_WIDTH-1:0] fill,
    output logic [1:0]         state
);

    localparam logic [A_WIDTH-1:0] OFFSET_MIN_W = A_WIDTH'(OFFSET_MIN);
    localparam logic [A_WIDTH-1:0] ONE          = A_WIDTH'(1);

    function automatic logic [A_WIDTH-1:0] clamp_offset(input logic [A_WIDTH-1:0] v);
        return (v == '0) ? OFFSET_MIN_W : v;
    endfunction

    ctrl_state_t        state_q;
    logic               en_q;
    logic               wr_q;
    logic               rd_q;
    logic               out_valid_q;
    logic [A_WIDTH-1:0] offset_q;
    logic [A_WIDTH-1:0] fill_q;
    logic [A_WIDTH-1:0] new_off;
    logic               active;
    logic               fill_clr;
    logic               fill_ld1;
    logic               fill_inc;

    // Counter controls mirror the FSM priority order: stop > offset_load > start > tick.
    always_comb begin
        new_off  = clamp_offset(offset_in);
        active   = (state_q != IDLE);
        fill_clr = 1'b0;
        fill_ld1 = 1'b0;
        fill_inc = 1'b0;
        if (!stop) begin
            if (offset_load) begin
                fill_ld1 = active && sample_tick;
                fill_clr = active && !sample_tick;
            end else if (!active) begin
                fill_clr = start;
            end else begin
                fill_inc = sample_tick;
            end
        end
    end

    sigdelay_fill_counter #(
        .A_WIDTH (A_WIDTH)
    ) u_fill (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (fill_clr),
        .ld1_i   (fill_ld1),
        .inc_i   (fill_inc),
        .max_i   (offset_q),
        .count_o (fill_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            en_q        <= 1'b0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            out_valid_q <= 1'b0;
            offset_q    <= OFFSET_MIN_W;
        end else begin
            en_q <= 1'b0;
            wr_q <= 1'b0;
            rd_q <= 1'b0;
            if (stop) begin
                state_q     <= IDLE;
                out_valid_q <= 1'b0;
            end else if (offset_load) begin
                offset_q <= new_off;
                if (state_q != IDLE) begin
                    out_valid_q <= 1'b0;
                    if (sample_tick) begin
                        en_q    <= 1'b1;
                        wr_q    <= 1'b1;
                        state_q <= (new_off == OFFSET_MIN_W) ? RUN : PRIME;
                    end else begin
                        state_q <= PRIME;
                    end
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            state_q <= PRIME;
                        end
                    end
                    PRIME: begin
                        if (sample_tick) begin
                            en_q <= 1'b1;
                            wr_q <= 1'b1;
                            // This write fills the buffer to the offset depth.
                            if (fill_q == offset_q - ONE) begin
                                state_q <= RUN;
                            end
                        end
                    end
                    RUN: begin
                        if (sample_tick) begin
                            en_q <= 1'b1;
                            wr_q <= 1'b1;
                            rd_q <= 1'b1;
                        end
                        // RAM read data lands one cycle after rd.
                        if (rd_q) begin
                            out_valid_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign en        = en_q;
    assign wr        = wr_q;
    assign rd        = rd_q;
    assign out_valid = out_valid_q;
    assign offset    = offset_q;
    assign fill      = fill_q;
    assign state     = state_q;

endmodule
